// File: rtl/lc3b_pkg.sv
// Shared LC-3b definitions used by the fetch unit and the control path:
// word width, PC increment and the fetch FSM state encoding.
package lc3b_pkg;
  localparam int LC3B_WORD_W = 16;
  localparam logic [LC3B_WORD_W-1:0] LC3B_PC_INC = 16'd2;

  typedef enum logic [1:0] {
    FS_IDLE  = 2'd0,
    FS_FETCH = 2'd1,
    FS_HOLD  = 2'd2,
    FS_ERROR = 2'd3
  } fetch_state_e;
endpackage

// File: rtl/lc3b_fetch_unit.sv
// LC-3b instruction fetch + IR: ready-handshake memory reads, PC tracking and
// redirect with squash of in-flight reads. LC3B_FETCH_TIMEOUT_EN adds a wait timeout.
module lc3b_fetch_unit
  import lc3b_pkg::*;
#(
  parameter logic [LC3B_WORD_W-1:0] RESET_PC       = 16'h0000,
  parameter int                     TIMEOUT_CYCLES = 255
) (
  input  logic                   clk,
  input  logic                   reset_n,
  output logic [LC3B_WORD_W-1:0] mem_addr,
  output logic                   mem_rd,
  input  logic                   mem_r,
  input  logic [LC3B_WORD_W-1:0] mem_rdata,
  output logic [LC3B_WORD_W-1:0] inst,
  output logic                   inst_valid,
  input  logic                   inst_ack,
  output logic [LC3B_WORD_W-1:0] inst_pc,
  output logic [LC3B_WORD_W-1:0] inst_npc,
  input  logic                   redirect,
  input  logic [LC3B_WORD_W-1:0] redirect_pc,
  output logic                   fetch_err
);
  localparam logic [LC3B_WORD_W-1:0] RST_PC = {RESET_PC[LC3B_WORD_W-1:1], 1'b0};

  fetch_state_e           state_q, state_d;
  logic [LC3B_WORD_W-1:0] pc_q, pc_d;
  logic [LC3B_WORD_W-1:0] fetch_addr_q, fetch_addr_d;
  logic                   squash_q, squash_d;
  logic [LC3B_WORD_W-1:0] ir_q, ir_d;
  logic [LC3B_WORD_W-1:0] inst_pc_q, inst_pc_d;
  logic [LC3B_WORD_W-1:0] inst_npc_q, inst_npc_d;
  logic [LC3B_WORD_W-1:0] tgt;
  logic                   unused_tgt_bit0;

  assign tgt             = {redirect_pc[LC3B_WORD_W-1:1], 1'b0};
  assign unused_tgt_bit0 = redirect_pc[0];

`ifdef LC3B_FETCH_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT_CYCLES - 1);
  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;
`endif

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    fetch_addr_d = fetch_addr_q;
    squash_d     = squash_q;
    ir_d         = ir_q;
    inst_pc_d    = inst_pc_q;
    inst_npc_d   = inst_npc_q;
`ifdef LC3B_FETCH_TIMEOUT_EN
    cnt_d = (state_q == FS_FETCH) ? cnt_q : '0;
    err_d = err_q;
`endif
    case (state_q)
      FS_IDLE: begin
        state_d      = FS_FETCH;
        pc_d         = redirect ? tgt : pc_q;
        fetch_addr_d = redirect ? tgt : pc_q;
      end
      FS_FETCH: begin
        if (redirect) pc_d = tgt;
        if (mem_r) begin
`ifdef LC3B_FETCH_TIMEOUT_EN
          cnt_d = '0;
`endif
          // Squashed or just-redirected data is dropped; the address only
          // moves once the outstanding read has completed.
          if (squash_q || redirect) begin
            squash_d     = 1'b0;
            fetch_addr_d = redirect ? tgt : pc_q;
          end else begin
            ir_d       = mem_rdata;
            inst_pc_d  = fetch_addr_q;
            inst_npc_d = fetch_addr_q + LC3B_PC_INC;
            pc_d       = fetch_addr_q + LC3B_PC_INC;
            state_d    = FS_HOLD;
          end
        end else begin
          if (redirect) squash_d = 1'b1;
`ifdef LC3B_FETCH_TIMEOUT_EN
          if (cnt_q == CNT_MAX) begin
            state_d = FS_ERROR;
            err_d   = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
`endif
        end
      end
      FS_HOLD: begin
        // Redirect beats a simultaneous acknowledge.
        if (redirect) begin
          pc_d         = tgt;
          fetch_addr_d = tgt;
          state_d      = FS_FETCH;
        end else if (inst_ack) begin
          fetch_addr_d = pc_q;
          state_d      = FS_FETCH;
        end
      end
      FS_ERROR: ;
      default: state_d = FS_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= FS_IDLE;
      pc_q         <= RST_PC;
      fetch_addr_q <= RST_PC;
      squash_q     <= 1'b0;
      ir_q         <= '0;
      inst_pc_q    <= RST_PC;
      inst_npc_q   <= RST_PC + LC3B_PC_INC;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      fetch_addr_q <= fetch_addr_d;
      squash_q     <= squash_d;
      ir_q         <= ir_d;
      inst_pc_q    <= inst_pc_d;
      inst_npc_q   <= inst_npc_d;
    end
  end

`ifdef LC3B_FETCH_TIMEOUT_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end
  assign fetch_err = err_q;
`else
  // Folds to constant 0 for any meaningful timeout value.
  assign fetch_err = (TIMEOUT_CYCLES < 0);
`endif

  assign mem_addr   = fetch_addr_q;
  assign mem_rd     = (state_q == FS_FETCH);
  assign inst       = ir_q;
  assign inst_valid = (state_q == FS_HOLD);
  assign inst_pc    = inst_pc_q;
  assign inst_npc   = inst_npc_q;
endmodule
